gfx_vram_arbiter: RTL and testbench

//  Shares one synchronous VRAM read port between NUM_REQ graphics fetch engines.

---
 rtl/gfx_arb_pkg.sv | 24 ++
 rtl/gfx_vram_arbiter_rr_picker.sv | 39 +++
 rtl/gfx_vram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_gfx_vram_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gfx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gfx_arb_pkg
// Description : Shared types and helpers for the VRAM read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gfx_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

    // Index of the set bit of a one-hot vector (0 when the vector is empty)
    function automatic req_idx_t onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = req_idx_t'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gfx_vram_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Picks the first set request bit scanning upward from a start
//               index, wrapping at N-1 back to 0. Result is one-hot or zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import gfx_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  req_idx_t     start,
    output logic [N-1:0] gnt
);

    logic w_found;
    int   w_pos;

    // Walk the N positions starting at 'start' and grant the first requester
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(start) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            for (int j = 0; j < N; j++) begin
                if (!w_found && (j == w_pos) && req[j]) begin
                    gnt[j]  = 1'b1;
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gfx_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gfx_vram_arbiter
// Description : Shares one synchronous VRAM read port between NUM_REQ fetch
//               engines. Requester 0 has fixed priority, the others share the
//               rest round-robin, and a starved low requester pre-empts 0
//               after MAX_WAIT cycles. A tag pipeline routes read data back.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_vram_arbiter
    import gfx_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 7
) (
    input  logic                      clock,
    input  logic                      rst_b,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int                 c_cnt_w    = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_wait_sat = c_cnt_w'(MAX_WAIT);
    localparam req_idx_t           c_last_idx = req_idx_t'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_low_mask = ~NUM_REQ'(1);

    logic [NUM_REQ-1:0][c_cnt_w-1:0]      r_wait_cnt;
    req_idx_t                             r_rr_ptr;
    logic [READ_LATENCY-1:0][NUM_REQ-1:0] r_tag;
    logic [NUM_REQ-1:0]                   r_pend;

    logic [NUM_REQ-1:0] w_starve;
    logic [NUM_REQ-1:0] w_low_req;
    logic [NUM_REQ-1:0] w_starve_gnt;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_adv;
    logic [MAX_REQ-1:0] w_gnt_ext;
    req_idx_t           w_gnt_idx;

    // Low requesters whose wait counter has saturated (bit 0 never starves)
    always_comb begin
        w_starve = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_starve[i] = (i != 0) && req[i] && (r_wait_cnt[i] == c_wait_sat);
        end
    end

    assign w_low_req = req & c_low_mask;

    // Starved requesters are served lowest index first
    rr_picker #(.N(NUM_REQ)) u_starve_pick (
        .req   (w_starve),
        .start (req_idx_t'(1)),
        .gnt   (w_starve_gnt)
    );

    // Normal round-robin among requesters 1..NUM_REQ-1
    rr_picker #(.N(NUM_REQ)) u_rr_pick (
        .req   (w_low_req),
        .start (r_rr_ptr),
        .gnt   (w_rr_gnt)
    );

    // Priority: starved low requester, then requester 0, then round-robin
    always_comb begin
        w_gnt = '0;
        w_adv = 1'b0;
        if (rst_b) begin
            if (|w_starve) begin
                w_gnt = w_starve_gnt;
                w_adv = 1'b1;
            end else if (req[0]) begin
                w_gnt[0] = 1'b1;
            end else if (|w_low_req) begin
                w_gnt = w_rr_gnt;
                w_adv = 1'b1;
            end
        end
    end

    // Address of the granted requester drives the VRAM port
    always_comb begin
        mem_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) mem_addr = addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign gnt    = w_gnt;
    assign mem_en = |w_gnt;

    // Widen the grant so the shared one-hot decoder can be used
    always_comb begin
        w_gnt_ext              = '0;
        w_gnt_ext[NUM_REQ-1:0] = w_gnt;
    end

    assign w_gnt_idx = onehot_to_idx(w_gnt_ext);

    // Round-robin pointer moves past the low requester just served
    always_ff @(posedge clock) begin
        if (!rst_b) begin
            r_rr_ptr <= req_idx_t'(1);
        end else if (w_adv) begin
            r_rr_ptr <= (w_gnt_idx == c_last_idx) ? req_idx_t'(1) : w_gnt_idx + 1'b1;
        end
    end

    // Per-requester wait counters, saturating at MAX_WAIT
    always_ff @(posedge clock) begin
        if (!rst_b) begin
            r_wait_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((i == 0) || !req[i] || w_gnt[i]) begin
                    r_wait_cnt[i] <= '0;
                end else if (r_wait_cnt[i] != c_wait_sat) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Grant tags follow the memory latency so data can be routed back
    always_ff @(posedge clock) begin
        if (!rst_b) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= w_gnt;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign rvalid = rst_b ? r_tag[READ_LATENCY-1] : '0;
    assign rdata  = (|rvalid) ? mem_rdata : '0;

    // Remember which requesters were left waiting this cycle
    always_ff @(posedge clock) begin
        if (!rst_b) begin
            r_pend <= '0;
        end else begin
            r_pend <= req & ~w_gnt;
        end
    end

    // A waiting requester must keep its request up until it is granted
    always_ff @(posedge clock) begin
        if (rst_b) begin
            assert ((r_pend & ~req) == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gfx_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfx_vram_arbiter
// Description : Self-checking bench for gfx_vram_arbiter. Instance a uses the
//               default parameters, b has a 3-cycle read latency, d has four
//               requesters and a 2-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_vram_arbiter;

    localparam logic [15:0] A0 = 16'h0040;
    localparam logic [15:0] A1 = 16'h1111;
    localparam logic [15:0] A2 = 16'h2222;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] DD = 32'h12345678;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance a: defaults (3 requesters, latency 1)
    logic        a_rst;
    logic [2:0]  a_req, a_gnt, a_rvalid;
    logic [47:0] a_addr;
    logic [31:0] a_rdata;
    logic        a_mem_en;
    logic [15:0] a_mem_addr;
    logic [31:0] a_mem_rdata;

    gfx_vram_arbiter u_a (
        .clock(clk), .rst_b(a_rst), .req(a_req), .addr(a_addr), .gnt(a_gnt),
        .rvalid(a_rvalid), .rdata(a_rdata), .mem_en(a_mem_en),
        .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata)
    );

    // Instance b: latency 3 with a pipelined memory model
    logic        b_rst;
    logic [2:0]  b_req, b_gnt, b_rvalid;
    logic [47:0] b_addr;
    logic [31:0] b_rdata;
    logic        b_mem_en;
    logic [15:0] b_mem_addr;
    logic [31:0] b_mem_rdata;
    logic [15:0] b_pipe [3];

    gfx_vram_arbiter #(.READ_LATENCY(3)) u_b (
        .clock(clk), .rst_b(b_rst), .req(b_req), .addr(b_addr), .gnt(b_gnt),
        .rvalid(b_rvalid), .rdata(b_rdata), .mem_en(b_mem_en),
        .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata)
    );

    always @(posedge clk) begin
        b_pipe[0] <= b_mem_addr;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_mem_rdata = {16'hC0DE, b_pipe[2]};

    // Instance d: 4 requesters, latency 2
    logic        d_rst;
    logic [3:0]  d_req, d_gnt, d_rvalid;
    logic [63:0] d_addr;
    logic [31:0] d_rdata;
    logic        d_mem_en;
    logic [15:0] d_mem_addr;

    gfx_vram_arbiter #(.NUM_REQ(4), .READ_LATENCY(2)) u_d (
        .clock(clk), .rst_b(d_rst), .req(d_req), .addr(d_addr), .gnt(d_gnt),
        .rvalid(d_rvalid), .rdata(d_rdata), .mem_en(d_mem_en),
        .mem_addr(d_mem_addr), .mem_rdata(DD)
    );

    typedef struct {
        logic        rst_b;
        logic [2:0]  req;
        logic [2:0]  gnt;
        logic [15:0] maddr;
        logic [2:0]  rvalid;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst_b, input logic [2:0] req, input logic [2:0] gnt,
                                input logic [15:0] maddr, input logic [2:0] rvalid,
                                input logic [31:0] rdata);
        vec_t v;
        v.rst_b = rst_b; v.req = req; v.gnt = gnt;
        v.maddr = maddr; v.rvalid = rvalid; v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic b_chk(input int c, input logic [2:0] gnt, input logic [15:0] maddr,
                         input logic [2:0] rv, input logic [31:0] rd);
        chk($sformatf("b_gnt c%0d", c), b_gnt, gnt);
        chk($sformatf("b_mem_en c%0d", c), b_mem_en, |gnt);
        chk($sformatf("b_mem_addr c%0d", c), b_mem_addr, maddr);
        chk($sformatf("b_rvalid c%0d", c), b_rvalid, rv);
        chk($sformatf("b_rdata c%0d", c), b_rdata, rd);
    endtask

    task automatic d_chk(input int c, input logic [3:0] gnt, input logic [15:0] maddr,
                         input logic [3:0] rv, input logic [31:0] rd);
        chk($sformatf("d_gnt c%0d", c), d_gnt, gnt);
        chk($sformatf("d_mem_en c%0d", c), d_mem_en, |gnt);
        chk($sformatf("d_mem_addr c%0d", c), d_mem_addr, maddr);
        chk($sformatf("d_rvalid c%0d", c), d_rvalid, rv);
        chk($sformatf("d_rdata c%0d", c), d_rdata, rd);
    endtask

    initial begin
        a_rst = 1'b0; a_req = '0; a_addr = {A2, A1, A0}; a_mem_rdata = DB;
        b_rst = 1'b0; b_req = '0; b_addr = '0;
        d_rst = 1'b0; d_req = '0; d_addr = '0;

        // Reset held with all requests up: nothing leaves the arbiter
        for (int k = 0; k < 3; k++) add(1'b0, 3'b111, 3'b000, 16'h0, 3'b000, 32'h0);
        // Single read from requester 0, data back one cycle later
        add(1'b1, 3'b001, 3'b001, A0, 3'b000, 32'h0);
        add(1'b1, 3'b000, 3'b000, 16'h0, 3'b001, DB);
        // Round-robin between requesters 1 and 2
        add(1'b1, 3'b110, 3'b010, A1, 3'b000, 32'h0);
        add(1'b1, 3'b110, 3'b100, A2, 3'b010, DB);
        add(1'b1, 3'b110, 3'b010, A1, 3'b100, DB);
        add(1'b1, 3'b110, 3'b100, A2, 3'b010, DB);
        add(1'b1, 3'b110, 3'b010, A1, 3'b100, DB);
        add(1'b1, 3'b110, 3'b100, A2, 3'b010, DB);
        add(1'b0, 3'b110, 3'b000, 16'h0, 3'b000, 32'h0);
        add(1'b0, 3'b000, 3'b000, 16'h0, 3'b000, 32'h0);
        // Starvation: requester 0 held, both low counters saturate together,
        // so 1 then 2 are served back to back; then 1 again 8 cycles later
        add(1'b1, 3'b111, 3'b001, A0, 3'b000, 32'h0);
        for (int k = 0; k < 6; k++) add(1'b1, 3'b111, 3'b001, A0, 3'b001, DB);
        add(1'b1, 3'b111, 3'b010, A1, 3'b001, DB);
        add(1'b1, 3'b111, 3'b100, A2, 3'b010, DB);
        add(1'b1, 3'b111, 3'b001, A0, 3'b100, DB);
        for (int k = 0; k < 5; k++) add(1'b1, 3'b111, 3'b001, A0, 3'b001, DB);
        add(1'b1, 3'b111, 3'b010, A1, 3'b001, DB);
        add(1'b1, 3'b111, 3'b100, A2, 3'b010, DB);
        add(1'b0, 3'b111, 3'b000, 16'h0, 3'b000, 32'h0);
        add(1'b0, 3'b000, 3'b000, 16'h0, 3'b000, 32'h0);

        next();
        foreach (vecs[n]) begin
            a_rst = vecs[n].rst_b;
            a_req = vecs[n].req;
            #4;
            chk($sformatf("a_gnt row%0d", n), a_gnt, vecs[n].gnt);
            chk($sformatf("a_mem_en row%0d", n), a_mem_en, |vecs[n].gnt);
            chk($sformatf("a_mem_addr row%0d", n), a_mem_addr, vecs[n].maddr);
            chk($sformatf("a_rvalid row%0d", n), a_rvalid, vecs[n].rvalid);
            chk($sformatf("a_rdata row%0d", n), a_rdata, vecs[n].rdata);
            next();
        end

        // Latency 3: grants 1,2,1 return in order with per-address data
        b_rst = 1'b1; b_req = 3'b110; b_addr = {16'h0201, 16'h0100, 16'h0000};
        #4; b_chk(0, 3'b010, 16'h0100, 3'b000, 32'h0); next();
        b_addr = {16'h0201, 16'h0102, 16'h0000};
        #4; b_chk(1, 3'b100, 16'h0201, 3'b000, 32'h0); next();
        b_req = 3'b010;
        #4; b_chk(2, 3'b010, 16'h0102, 3'b000, 32'h0); next();
        b_req = 3'b000;
        #4; b_chk(3, 3'b000, 16'h0, 3'b010, 32'hC0DE0100); next();
        #4; b_chk(4, 3'b000, 16'h0, 3'b100, 32'hC0DE0201); next();
        #4; b_chk(5, 3'b000, 16'h0, 3'b010, 32'hC0DE0102); next();
        #4; b_chk(6, 3'b000, 16'h0, 3'b000, 32'h0); next();

        // Reset one cycle after a grant to 2 (pointer then at 3): the read is
        // dropped and the pointer restarts at 1
        d_rst = 1'b1; d_req = 4'b0100; d_addr = {16'h0000, 16'h0300, 16'h0310, 16'h0000};
        #4; d_chk(0, 4'b0100, 16'h0300, 4'b0000, 32'h0); next();
        d_rst = 1'b0; d_req = 4'b0000;
        #4; d_chk(1, 4'b0000, 16'h0, 4'b0000, 32'h0); next();
        d_rst = 1'b1; d_req = 4'b1110;
        #4; d_chk(2, 4'b0010, 16'h0310, 4'b0000, 32'h0); next();
        #4; d_chk(3, 4'b0100, 16'h0300, 4'b0000, 32'h0); next();
        #4; d_chk(4, 4'b1000, 16'h0000, 4'b0010, DD); next();
        d_rst = 1'b0;
        next();
        d_req = 4'b0000;
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
